// File: rtl/match_timer.sv
// Scoreboard match clock: BCD MM:SS up/down counter with prescaler,
// run control, clamped preset load and one-cycle tick/expiry pulses.
module match_timer #(
    parameter int CLK_FREQ     = 25000000,
    parameter int PRESC_W      = 25,
    parameter int MAX_MIN_TENS = 9
) (
    input  logic       clk_tm,
    input  logic       rst_tm,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic       dir_down,
    input  logic [3:0] preset_min_tens,
    input  logic [3:0] preset_min_units,
    input  logic [2:0] preset_sec_tens,
    input  logic [3:0] preset_sec_units,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       running,
    output logic       tick_1hz,
    output logic       done
);

    localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_FREQ - 1);
    localparam logic [3:0]         MT_MAX   = 4'(MAX_MIN_TENS);

    logic [PRESC_W-1:0] presc;

    logic [3:0] ld_mt;
    logic [3:0] ld_mu;
    logic [2:0] ld_st;
    logic [3:0] ld_su;

    logic [3:0] up_mt;
    logic [3:0] up_mu;
    logic [2:0] up_st;
    logic [3:0] up_su;

    logic [3:0] dn_mt;
    logic [3:0] dn_mu;
    logic [2:0] dn_st;
    logic [3:0] dn_su;

    logic at_zero;
    logic at_max;
    logic up_to_max;
    logic dn_to_zero;
    logic presc_wrap;
    logic can_run;

    assign ld_mt = (preset_min_tens  > MT_MAX) ? MT_MAX : preset_min_tens;
    assign ld_mu = (preset_min_units > 4'd9)   ? 4'd9   : preset_min_units;
    assign ld_st = (preset_sec_tens  > 3'd5)   ? 3'd5   : preset_sec_tens;
    assign ld_su = (preset_sec_units > 4'd9)   ? 4'd9   : preset_sec_units;

    assign at_zero = (min_tens == 4'd0) && (min_units == 4'd0) &&
                     (sec_tens == 3'd0) && (sec_units == 4'd0);

    assign at_max = (min_tens == MT_MAX) && (min_units == 4'd9) &&
                    (sec_tens == 3'd5)   && (sec_units == 4'd9);

    assign up_to_max = (up_mt == MT_MAX) && (up_mu == 4'd9) &&
                       (up_st == 3'd5)   && (up_su == 4'd9);

    assign dn_to_zero = (dn_mt == 4'd0) && (dn_mu == 4'd0) &&
                        (dn_st == 3'd0) && (dn_su == 4'd0);

    assign presc_wrap = (presc == PRESC_TC);

    // A start only takes hold if the current direction has room to move.
    assign can_run = dir_down ? !at_zero : !at_max;

    always_comb begin
        up_mt = min_tens;
        up_mu = min_units;
        up_st = sec_tens;
        up_su = sec_units;
        if (sec_units != 4'd9) begin
            up_su = sec_units + 4'd1;
        end else begin
            up_su = 4'd0;
            if (sec_tens != 3'd5) begin
                up_st = sec_tens + 3'd1;
            end else begin
                up_st = 3'd0;
                if (min_units != 4'd9) begin
                    up_mu = min_units + 4'd1;
                end else begin
                    up_mu = 4'd0;
                    up_mt = min_tens + 4'd1;
                end
            end
        end
    end

    always_comb begin
        dn_mt = min_tens;
        dn_mu = min_units;
        dn_st = sec_tens;
        dn_su = sec_units;
        if (sec_units != 4'd0) begin
            dn_su = sec_units - 4'd1;
        end else begin
            dn_su = 4'd9;
            if (sec_tens != 3'd0) begin
                dn_st = sec_tens - 3'd1;
            end else begin
                dn_st = 3'd5;
                if (min_units != 4'd0) begin
                    dn_mu = min_units - 4'd1;
                end else begin
                    dn_mu = 4'd9;
                    dn_mt = min_tens - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_tm or posedge rst_tm) begin
        if (rst_tm) begin
            min_tens  <= '0;
            min_units <= '0;
            sec_tens  <= '0;
            sec_units <= '0;
            presc     <= '0;
            running   <= 1'b0;
            tick_1hz  <= 1'b0;
            done      <= 1'b0;
        end else begin
            tick_1hz <= 1'b0;
            done     <= 1'b0;
            priority case (1'b1)
                clear: begin
                    {min_tens, min_units, sec_tens, sec_units} <= '0;
                    presc   <= '0;
                    running <= 1'b0;
                end
                load: begin
                    {min_tens, min_units, sec_tens, sec_units} <=
                        {ld_mt, ld_mu, ld_st, ld_su};
                    presc   <= '0;
                    running <= 1'b0;
                end
                stop: begin
                    running <= 1'b0;
                end
                running: begin
                    if (presc_wrap) begin
                        presc    <= '0;
                        tick_1hz <= 1'b1;
                        // A step with no room (direction flipped at a
                        // limit) holds the digits and ends the run.
                        if (dir_down) begin
                            if (at_zero || dn_to_zero) begin
                                done    <= 1'b1;
                                running <= 1'b0;
                            end
                            if (!at_zero) begin
                                {min_tens, min_units, sec_tens, sec_units} <=
                                    {dn_mt, dn_mu, dn_st, dn_su};
                            end
                        end else begin
                            if (at_max || up_to_max) begin
                                done    <= 1'b1;
                                running <= 1'b0;
                            end
                            if (!at_max) begin
                                {min_tens, min_units, sec_tens, sec_units} <=
                                    {up_mt, up_mu, up_st, up_su};
                            end
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                start: begin
                    running <= can_run;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_match_timer.sv
// Bench for match_timer: directed scenarios plus randomized commands
// checked each cycle against a seconds-based reference model.
module tb_match_timer;

    localparam int CF   = 4;
    localparam int MT   = 9;
    localparam int MAXS = MT * 600 + 599;

    logic       clk_tm   = 1'b0;
    logic       rst_tm   = 1'b1;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       clear    = 1'b0;
    logic       load     = 1'b0;
    logic       dir_down = 1'b0;
    logic [3:0] p_mt     = '0;
    logic [3:0] p_mu     = '0;
    logic [2:0] p_st     = '0;
    logic [3:0] p_su     = '0;

    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [2:0] sec_tens;
    logic [3:0] sec_units;
    logic       running;
    logic       tick_1hz;
    logic       done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int m_secs = 0;
    int m_pc   = 0;
    bit m_run  = 1'b0;
    bit m_tick = 1'b0;
    bit m_done = 1'b0;

    logic [17:0] dut_vec;

    match_timer #(
        .CLK_FREQ    (CF),
        .PRESC_W     (3),
        .MAX_MIN_TENS(MT)
    ) dut (
        .clk_tm          (clk_tm),
        .rst_tm          (rst_tm),
        .start           (start),
        .stop            (stop),
        .clear           (clear),
        .load            (load),
        .dir_down        (dir_down),
        .preset_min_tens (p_mt),
        .preset_min_units(p_mu),
        .preset_sec_tens (p_st),
        .preset_sec_units(p_su),
        .min_tens        (min_tens),
        .min_units       (min_units),
        .sec_tens        (sec_tens),
        .sec_units       (sec_units),
        .running         (running),
        .tick_1hz        (tick_1hz),
        .done            (done)
    );

    always #5 clk_tm = ~clk_tm;

    assign dut_vec = {min_tens, min_units, sec_tens, sec_units,
                      running, tick_1hz, done};

    function automatic logic [17:0] exp_vec(int s, bit r, bit t, bit d);
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] c;
        logic [3:0] e;
        a = 4'(s / 600);
        b = 4'((s / 60) % 10);
        c = 3'((s % 60) / 10);
        e = 4'(s % 10);
        return {a, b, c, e, r, t, d};
    endfunction

    function automatic int clamp_secs(int a, int b, int c, int d);
        int ca;
        int cb;
        int cc;
        int cd;
        ca = (a > MT) ? MT : a;
        cb = (b > 9) ? 9 : b;
        cc = (c > 5) ? 5 : c;
        cd = (d > 9) ? 9 : d;
        return ca * 600 + cb * 60 + cc * 10 + cd;
    endfunction

    function automatic int disp();
        return int'(min_tens) * 1000 + int'(min_units) * 100 +
               int'(sec_tens) * 10 + int'(sec_units);
    endfunction

    // Time held as whole seconds; digits are derived only for comparison.
    always @(posedge clk_tm or posedge rst_tm) begin : model
        int s;
        int pc;
        bit r;
        bit t;
        bit d;
        s  = m_secs;
        pc = m_pc;
        r  = m_run;
        t  = 1'b0;
        d  = 1'b0;
        if (rst_tm) begin
            s  = 0;
            pc = 0;
            r  = 1'b0;
        end else if (clear) begin
            s  = 0;
            pc = 0;
            r  = 1'b0;
        end else if (load) begin
            s  = clamp_secs(int'(p_mt), int'(p_mu), int'(p_st), int'(p_su));
            pc = 0;
            r  = 1'b0;
        end else if (stop) begin
            r = 1'b0;
        end else if (r) begin
            if (pc == CF - 1) begin
                pc = 0;
                t  = 1'b1;
                if (dir_down) begin
                    if (s > 0) s = s - 1;
                    if (s == 0) begin
                        d = 1'b1;
                        r = 1'b0;
                    end
                end else begin
                    if (s < MAXS) s = s + 1;
                    if (s == MAXS) begin
                        d = 1'b1;
                        r = 1'b0;
                    end
                end
            end else begin
                pc = pc + 1;
            end
        end else if (start) begin
            r = dir_down ? (s != 0) : (s != MAXS);
        end
        m_secs <= s;
        m_pc   <= pc;
        m_run  <= r;
        m_tick <= t;
        m_done <= d;
    end

    always @(negedge clk_tm) begin
        if (chk_en) begin
            total++;
            if (dut_vec !== exp_vec(m_secs, m_run, m_tick, m_done)) begin
                bad++;
                $display("FAIL cycle t=%0t got=%h want=%h", $time, dut_vec,
                         exp_vec(m_secs, m_run, m_tick, m_done));
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic pulse(input bit c, input bit l, input bit sp, input bit st);
        clear = c;
        load  = l;
        stop  = sp;
        start = st;
        @(negedge clk_tm);
        clear = 1'b0;
        load  = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_tm);
    endtask

    task automatic set_preset(input int a, input int b, input int c, input int d);
        p_mt = 4'(a);
        p_mu = 4'(b);
        p_st = 3'(c);
        p_su = 4'(d);
    endtask

    initial begin
        int ticks;
        int gaps;
        int dn;
        int last;

        wait_n(2);
        chk_en = 1'b1;
        chk("rst_disp", disp(), 0);
        chk("rst_run", int'(running), 0);
        chk("rst_tick", int'(tick_1hz), 0);
        chk("rst_done", int'(done), 0);
        rst_tm = 1'b0;
        wait_n(1);

        // Scenario 1: free-running up count
        dir_down = 1'b0;
        pulse(0, 0, 0, 1);
        ticks = 0;
        gaps  = 0;
        dn    = 0;
        last  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_tm);
            if (tick_1hz) begin
                if (i - last != 4) gaps++;
                last = i;
                ticks++;
            end
            if (done) dn++;
        end
        chk("t1_disp", disp(), 10);
        chk("t1_ticks", ticks, 10);
        chk("t1_gaps", gaps, 0);
        chk("t1_done", dn, 0);

        // Scenario 2: countdown to expiry
        dir_down = 1'b1;
        set_preset(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        chk("t2_load", disp(), 100);
        chk("t2_load_run", int'(running), 0);
        pulse(0, 0, 0, 1);
        wait_n(4);
        chk("t2_first", disp(), 59);
        wait_n(235);
        chk("t2_pre_disp", disp(), 1);
        chk("t2_pre_done", int'(done), 0);
        wait_n(1);
        chk("t2_exp_disp", disp(), 0);
        chk("t2_exp_done", int'(done), 1);
        chk("t2_exp_tick", int'(tick_1hz), 1);
        chk("t2_exp_run", int'(running), 0);
        wait_n(1);
        chk("t2_done_1cyc", int'(done), 0);
        pulse(0, 0, 0, 1);
        wait_n(8);
        chk("t2_restart_run", int'(running), 0);
        chk("t2_restart_disp", disp(), 0);

        // Scenario 3: up-count saturation
        dir_down = 1'b0;
        set_preset(9, 8, 5, 9);
        pulse(0, 1, 0, 0);
        chk("t3_load", disp(), 9859);
        pulse(0, 0, 0, 1);
        wait_n(239);
        chk("t3_pre_disp", disp(), 9958);
        chk("t3_pre_done", int'(done), 0);
        wait_n(1);
        chk("t3_sat_disp", disp(), 9959);
        chk("t3_sat_done", int'(done), 1);
        chk("t3_sat_run", int'(running), 0);
        wait_n(12);
        pulse(0, 0, 0, 1);
        wait_n(4);
        chk("t3_hold_disp", disp(), 9959);
        chk("t3_hold_run", int'(running), 0);

        // Scenario 4: pause keeps the partial second
        pulse(1, 0, 0, 0);
        dir_down = 1'b0;
        pulse(0, 0, 0, 1);
        wait_n(2);
        pulse(0, 0, 1, 0);
        wait_n(10);
        chk("t4_paused_disp", disp(), 0);
        chk("t4_paused_run", int'(running), 0);
        pulse(0, 0, 0, 1);
        wait_n(1);
        chk("t4_early_tick", int'(tick_1hz), 0);
        wait_n(1);
        chk("t4_tick", int'(tick_1hz), 1);
        chk("t4_disp", disp(), 1);

        // Scenario 5: clamped load, then clear beats load
        set_preset(1, 12, 7, 15);
        pulse(0, 1, 0, 0);
        chk("t5_clamp", disp(), 1959);
        pulse(1, 1, 0, 0);
        chk("t5_clear_wins", disp(), 0);

        // Scenario 6: asynchronous reset mid-second
        set_preset(0, 0, 0, 5);
        dir_down = 1'b1;
        pulse(0, 1, 0, 0);
        pulse(0, 0, 0, 1);
        wait_n(6);
        chk("t6_pre_disp", disp(), 4);
        @(posedge clk_tm);
        #3 rst_tm = 1'b1;
        #1;
        chk("t6_rst_disp", disp(), 0);
        chk("t6_rst_run", int'(running), 0);
        chk("t6_rst_tick", int'(tick_1hz), 0);
        chk("t6_rst_done", int'(done), 0);
        @(negedge clk_tm);
        rst_tm   = 1'b0;
        dir_down = 1'b0;
        pulse(0, 0, 0, 1);
        wait_n(3);
        chk("t6_early_tick", int'(tick_1hz), 0);
        wait_n(1);
        chk("t6_tick", int'(tick_1hz), 1);
        chk("t6_disp", disp(), 1);

        // Randomized commands, presets and direction changes
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            clear = ($urandom_range(0, 99) == 0);
            load  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) dir_down = ~dir_down;
            if ($urandom_range(0, 1) == 1) begin
                set_preset($urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 7), $urandom_range(0, 15));
            end else begin
                set_preset(0, 0, 0, $urandom_range(0, 9));
            end
            rst_tm = 1'b0;
            if ($urandom_range(0, 599) == 0) begin
                #2 rst_tm = 1'b1;
            end
            @(negedge clk_tm);
        end
        start  = 1'b0;
        stop   = 1'b0;
        clear  = 1'b0;
        load   = 1'b0;
        rst_tm = 1'b0;
        wait_n(2);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
